// File: rtl/rhythm_score_keeper.sv
// Judgement accumulator for the rhythm game.
// Consumes per-note hit judgements and keeps running score, combo, max combo and a two-digit
// BCD accuracy percentage computed by a multi-cycle restoring divider.
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   game_start   one-cycle synchronous clear of all game state (wins over judge_valid)
//   judge_valid  judgement present this cycle, always accepted
//   judge_type   0 = MISS, 1 = GOOD, 2 = PERFECT, 3 = reserved (ignored)
//   score        accumulated score, saturates at 999_999
//   combo        current combo clamped to 0..9
//   max_combo    highest internal combo this game
//   accuracy     BCD percent {tens, units}
//   busy         accuracy recomputation in progress
module rhythm_score_keeper (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        game_start,
   input  logic        judge_valid,
   input  logic [1:0]  judge_type,
   output logic [31:0] score,
   output logic [3:0]  combo,
   output logic [7:0]  max_combo,
   output logic [7:0]  accuracy,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StDiv, StWrite} state_e;

   localparam logic [31:0] ScoreMax  = 32'd999_999;
   localparam logic [4:0]  DivSteps  = 5'd24;

   state_e      state_q, state_d;
   logic [31:0] score_q, score_d;
   logic [7:0]  combo_q, combo_d;
   logic [7:0]  max_combo_q, max_combo_d;
   logic [15:0] n_perfect_q, n_perfect_d;
   logic [15:0] n_good_q, n_good_d;
   logic [15:0] n_total_q, n_total_d;
   logic [7:0]  accuracy_q, accuracy_d;
   logic        pending_q, pending_d;
   // Dividend shifts out MSB-first while quotient bits shift in at the bottom.
   logic [23:0] num_q, num_d;
   logic [16:0] rem_q, rem_d;
   logic [16:0] den_q, den_d;
   logic [4:0]  cnt_q, cnt_d;

   logic        accept;
   logic        is_hit;
   logic [5:0]  steps;
   logic [9:0]  gain;
   logic [31:0] score_sum;
   logic [16:0] weighted;
   logic [23:0] num_new;
   logic [17:0] rem_shift;
   logic [6:0]  quot;
   logic        latch_ops;

   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      combo_d     = combo_q;
      max_combo_d = max_combo_q;
      n_perfect_d = n_perfect_q;
      n_good_d    = n_good_q;
      n_total_d   = n_total_q;
      accuracy_d  = accuracy_q;
      pending_d   = pending_q;
      num_d       = num_q;
      rem_d       = rem_q;
      den_d       = den_q;
      cnt_d       = cnt_q;
      latch_ops   = 1'b0;
      quot        = 7'd0;

      accept    = judge_valid && (judge_type != 2'd3);
      is_hit    = (judge_type == 2'd1) || (judge_type == 2'd2);
      steps     = (combo_q > 8'd50) ? 6'd50 : combo_q[5:0];
      gain      = ((judge_type == 2'd2) ? 10'd300 : 10'd100) + ({4'd0, steps} * 10'd10);
      score_sum = score_q + {22'd0, gain};

      // Judgement bookkeeping
      if (accept) begin
         if (is_hit) begin
            score_d = (score_sum > ScoreMax) ? ScoreMax : score_sum;
            combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
            if (combo_d > max_combo_q) max_combo_d = combo_d;
         end else begin
            combo_d = 8'd0;
         end
         if (n_total_q != 16'hFFFF) begin
            n_total_d = n_total_q + 16'd1;
            if (judge_type == 2'd2) n_perfect_d = n_perfect_q + 16'd1;
            if (judge_type == 2'd1) n_good_d = n_good_q + 16'd1;
         end
      end

      // Operands always come from the post-update counters
      weighted  = {n_perfect_d, 1'b0} + {1'b0, n_good_d};
      num_new   = {7'd0, weighted} * 24'd100;
      rem_shift = {rem_q, num_q[23]};

      unique case (state_q)
         StIdle: begin
            if (accept) latch_ops = 1'b1;
         end
         StDiv: begin
            if (accept) pending_d = 1'b1;
            if (rem_shift >= {1'b0, den_q}) begin
               rem_d = 17'(rem_shift - {1'b0, den_q});
               num_d = {num_q[22:0], 1'b1};
            end else begin
               rem_d = rem_shift[16:0];
               num_d = {num_q[22:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == DivSteps - 5'd1) state_d = StWrite;
         end
         StWrite: begin
            if (pending_q) begin
               // Stale result: rerun with the latest counters and skip the write
               pending_d = 1'b0;
               latch_ops = 1'b1;
            end else begin
               quot = (num_q > 24'd99) ? 7'd99 : num_q[6:0];
               accuracy_d = (den_q == 17'd0) ? 8'h00
                          : {4'(quot / 7'd10), 4'(quot % 7'd10)};
               state_d = StIdle;
               // A judgement landing on the write cycle starts its own computation
               if (accept) latch_ops = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (latch_ops) begin
         state_d = StDiv;
         num_d   = num_new;
         den_d   = {n_total_d, 1'b0};
         rem_d   = 17'd0;
         cnt_d   = 5'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || game_start) begin
         state_q     <= StIdle;
         score_q     <= 32'd0;
         combo_q     <= 8'd0;
         max_combo_q <= 8'd0;
         n_perfect_q <= 16'd0;
         n_good_q    <= 16'd0;
         n_total_q   <= 16'd0;
         accuracy_q  <= 8'h00;
         pending_q   <= 1'b0;
         num_q       <= 24'd0;
         rem_q       <= 17'd0;
         den_q       <= 17'd0;
         cnt_q       <= 5'd0;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         combo_q     <= combo_d;
         max_combo_q <= max_combo_d;
         n_perfect_q <= n_perfect_d;
         n_good_q    <= n_good_d;
         n_total_q   <= n_total_d;
         accuracy_q  <= accuracy_d;
         pending_q   <= pending_d;
         num_q       <= num_d;
         rem_q       <= rem_d;
         den_q       <= den_d;
         cnt_q       <= cnt_d;
      end
   end

   assign score     = score_q;
   assign combo     = (combo_q > 8'd9) ? 4'd9 : combo_q[3:0];
   assign max_combo = max_combo_q;
   assign accuracy  = accuracy_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_rhythm_score_keeper.sv
// Self-checking bench for rhythm_score_keeper: a table of per-cycle vectors, hand-written
// timing sequences, and randomized bursts checked against a behavioural scoring model.
module tb_rhythm_score_keeper;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        game_start = 1'b0;
   logic        judge_valid = 1'b0;
   logic [1:0]  judge_type = 2'd0;
   logic [31:0] score;
   logic [3:0]  combo;
   logic [7:0]  max_combo;
   logic [7:0]  accuracy;
   logic        busy;

   int total = 0;
   int bad = 0;

   // Behavioural model state
   int m_score, m_combo, m_max, m_np, m_ng, m_nt;

   always #5 clk = ~clk;

   rhythm_score_keeper dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .game_start  (game_start),
      .judge_valid (judge_valid),
      .judge_type  (judge_type),
      .score       (score),
      .combo       (combo),
      .max_combo   (max_combo),
      .accuracy    (accuracy),
      .busy        (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d)", name, act, act, exp, exp);
      end
   endtask

   task automatic model_clear();
      m_score = 0; m_combo = 0; m_max = 0; m_np = 0; m_ng = 0; m_nt = 0;
   endtask

   task automatic model_apply(input logic gs, input logic v, input logic [1:0] t);
      int bonus;
      if (gs) begin
         model_clear();
      end else if (v && t != 2'd3) begin
         if (t == 2'd0) begin
            m_combo = 0;
         end else begin
            bonus = 10 * ((m_combo < 50) ? m_combo : 50);
            m_score = m_score + ((t == 2'd2) ? 300 : 100) + bonus;
            if (m_score > 999999) m_score = 999999;
            if (m_combo < 255) m_combo++;
            if (m_combo > m_max) m_max = m_combo;
         end
         if (m_nt < 65535) begin
            m_nt++;
            if (t == 2'd2) m_np++;
            if (t == 2'd1) m_ng++;
         end
      end
   endtask

   function automatic logic [7:0] model_acc();
      int q;
      if (m_nt == 0) return 8'h00;
      q = (100 * (2 * m_np + m_ng)) / (2 * m_nt);
      if (q > 99) q = 99;
      return 8'(((q / 10) << 4) | (q % 10));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic gs, input logic v, input logic [1:0] t);
      game_start = gs;
      judge_valid = v;
      judge_type = t;
      model_apply(gs, v, t);
      tick();
      game_start = 1'b0;
      judge_valid = 1'b0;
      judge_type = 2'd0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_score"}, score, 32'd0);
      check({tag, "_combo"}, 32'(combo), 32'd0);
      check({tag, "_max"}, 32'(max_combo), 32'd0);
      check({tag, "_acc"}, 32'(accuracy), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic       gs;
      logic       v;
      logic [1:0] t;
      int         sc;
      int         cb;
      int         mx;
   } vec_t;

   vec_t vecs[10];

   logic       r_gs, r_v;
   logic [1:0] r_t;
   int         rate, len, write_cyc, idle_cyc, changes, bound;
   logic [7:0] prev_acc;
   logic       saw_activity;

   initial begin
      model_clear();

      // Power-on reset held for two cycles
      repeat (2) tick();
      check_zero("reset");
      rst_n = 1'b1;
      tick();

      // Per-cycle vector table
      vecs[0] = '{1'b1, 1'b0, 2'd0, 0, 0, 0};
      vecs[1] = '{1'b0, 1'b1, 2'd2, 300, 1, 1};
      vecs[2] = '{1'b0, 1'b1, 2'd1, 410, 2, 2};
      vecs[3] = '{1'b0, 1'b1, 2'd3, 410, 2, 2};
      vecs[4] = '{1'b0, 1'b1, 2'd0, 410, 0, 2};
      vecs[5] = '{1'b0, 1'b1, 2'd2, 710, 1, 2};
      vecs[6] = '{1'b0, 1'b0, 2'd2, 710, 1, 2};
      vecs[7] = '{1'b1, 1'b1, 2'd2, 0, 0, 0};
      vecs[8] = '{1'b0, 1'b1, 2'd1, 100, 1, 1};
      vecs[9] = '{1'b0, 1'b1, 2'd2, 410, 2, 2};
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].gs, vecs[i].v, vecs[i].t);
         check($sformatf("vec%0d_score", i), score, 32'(vecs[i].sc));
         check($sformatf("vec%0d_combo", i), 32'(combo), 32'(vecs[i].cb));
         check($sformatf("vec%0d_max", i), 32'(max_combo), 32'(vecs[i].mx));
      end

      // Three spaced PERFECTs with exact write latency
      drive(1'b1, 1'b0, 2'd0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 2'd2);
         check($sformatf("p3_%0d_score", k), score, 32'(300 * (k + 1) + 10 * (k * (k + 1) / 2)));
         check($sformatf("p3_%0d_busy_on", k), 32'(busy), 32'd1);
         repeat (24) tick();
         check($sformatf("p3_%0d_acc_pre", k), 32'(accuracy), (k == 0) ? 32'h00 : 32'h99);
         check($sformatf("p3_%0d_busy_pre", k), 32'(busy), 32'd1);
         tick();
         check($sformatf("p3_%0d_acc", k), 32'(accuracy), 32'h99);
         check($sformatf("p3_%0d_busy_off", k), 32'(busy), 32'd0);
         repeat (4) tick();
      end
      check("p3_combo", 32'(combo), 32'd3);
      check("p3_max", 32'(max_combo), 32'd3);

      // PERFECT, GOOD, MISS, PERFECT spaced 30 cycles
      drive(1'b1, 1'b0, 2'd0);
      drive(1'b0, 1'b1, 2'd2); repeat (29) tick();
      check("pgmp_s1", score, 32'd300); check("pgmp_a1", 32'(accuracy), 32'h99);
      drive(1'b0, 1'b1, 2'd1); repeat (29) tick();
      check("pgmp_s2", score, 32'd410); check("pgmp_a2", 32'(accuracy), 32'h75);
      drive(1'b0, 1'b1, 2'd0); repeat (29) tick();
      check("pgmp_s3", score, 32'd410); check("pgmp_a3", 32'(accuracy), 32'h50);
      drive(1'b0, 1'b1, 2'd2); repeat (29) tick();
      check("pgmp_s4", score, 32'd710); check("pgmp_a4", 32'(accuracy), 32'h62);
      check("pgmp_combo", 32'(combo), 32'd1);
      check("pgmp_max", 32'(max_combo), 32'd2);

      // Back-to-back P, P, G, M: one rerun, a single write 50 cycles after the first
      drive(1'b1, 1'b0, 2'd0);
      drive(1'b0, 1'b1, 2'd2); check("b2b_s0", score, 32'd300); check("b2b_b0", 32'(busy), 32'd1);
      drive(1'b0, 1'b1, 2'd2); check("b2b_s1", score, 32'd610); check("b2b_b1", 32'(busy), 32'd1);
      drive(1'b0, 1'b1, 2'd1); check("b2b_s2", score, 32'd730); check("b2b_b2", 32'(busy), 32'd1);
      drive(1'b0, 1'b1, 2'd0); check("b2b_s3", score, 32'd730); check("b2b_b3", 32'(busy), 32'd1);
      write_cyc = -1; idle_cyc = -1; changes = 0; prev_acc = accuracy;
      for (int c = 4; c < 70; c++) begin
         tick();
         if (accuracy !== prev_acc) changes++;
         prev_acc = accuracy;
         if (accuracy != 8'h00 && write_cyc < 0) write_cyc = c;
         if (!busy && idle_cyc < 0) idle_cyc = c;
      end
      check("b2b_write_cyc", 32'(write_cyc), 32'd50);
      check("b2b_idle_cyc", 32'(idle_cyc), 32'd50);
      check("b2b_writes", 32'(changes), 32'd1);
      check("b2b_acc", 32'(accuracy), 32'h62);

      // game_start and PERFECT together mid-division
      drive(1'b1, 1'b0, 2'd0);
      drive(1'b0, 1'b1, 2'd2);
      repeat (10) tick();
      drive(1'b1, 1'b1, 2'd2);
      check_zero("gs_mid");
      saw_activity = 1'b0;
      repeat (40) begin
         tick();
         if (busy || accuracy != 8'h00) saw_activity = 1'b1;
      end
      check("gs_mid_quiet", 32'(saw_activity), 32'd0);

      // Reset in the middle of a division
      drive(1'b0, 1'b1, 2'd2);
      repeat (5) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      model_clear();
      check_zero("rst_mid");
      rst_n = 1'b1;
      saw_activity = 1'b0;
      repeat (40) begin
         tick();
         if (busy || accuracy != 8'h00) saw_activity = 1'b1;
      end
      check("rst_mid_quiet", 32'(saw_activity), 32'd0);

      // Twelve consecutive PERFECTs then a reserved type
      drive(1'b1, 1'b0, 2'd0);
      repeat (12) drive(1'b0, 1'b1, 2'd2);
      check("p12_score", score, 32'd4260);
      check("p12_combo", 32'(combo), 32'd9);
      check("p12_max", 32'(max_combo), 32'd12);
      bound = 0;
      while (busy && bound < 100) begin
         tick();
         bound++;
      end
      check("p12_busy_done", 32'(busy), 32'd0);
      check("p12_acc", 32'(accuracy), 32'h99);
      drive(1'b0, 1'b1, 2'd3);
      check("t3_score", score, 32'd4260);
      check("t3_combo", 32'(combo), 32'd9);
      check("t3_max", 32'(max_combo), 32'd12);
      check("t3_busy", 32'(busy), 32'd0);
      repeat (3) tick();
      check("t3_busy_later", 32'(busy), 32'd0);
      check("t3_acc", 32'(accuracy), 32'h99);

      // Randomized bursts separated by idle gaps, against the behavioural model
      drive(1'b1, 1'b0, 2'd0);
      for (int ph = 0; ph < 40; ph++) begin
         if (ph % 2 == 0) begin
            rate = $urandom_range(5, 80);
            len = $urandom_range(10, 80);
         end else begin
            rate = 0;
            len = 60;
         end
         for (int c = 0; c < len; c++) begin
            r_gs = ($urandom_range(0, 299) == 0);
            r_v = ($urandom_range(0, 99) < rate);
            r_t = 2'($urandom_range(0, 3));
            drive(r_gs, r_v, r_t);
            check("rnd_score", score, 32'(m_score));
            check("rnd_combo", 32'(combo), 32'((m_combo > 9) ? 9 : m_combo));
            check("rnd_max", 32'(max_combo), 32'(m_max));
            if (!busy) check("rnd_acc", 32'(accuracy), 32'(model_acc()));
         end
         if (ph % 2 == 1) check("rnd_gap_idle", 32'(busy), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rhythm_score_keeper.md
# rhythm_score_keeper

Judgement accumulator for the rhythm game. It consumes per-note hit judgements from the hit-detection logic and maintains running score, current combo, max combo and a two-digit BCD accuracy percentage. Its outputs feed the eight-digit seven-segment display driver directly (`score`, `combo`, `accuracy`). Accuracy is computed by an internal multi-cycle restoring divider, so no wide combinational divide is needed.

## Interface
- No parameters. Base scores are fixed: PERFECT = 300, GOOD = 100, MISS = 0, combo bonus step = 10, bonus cap = 50 steps.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `game_start` in 1: synchronous clear of all game state. One-cycle pulse.
- `judge_valid` in 1: a judgement is present this cycle. Always accepted; there is no back-pressure.
- `judge_type` in 2: 0 = MISS, 1 = GOOD, 2 = PERFECT, 3 = reserved.
- `score` out 32: accumulated score, binary, saturating at 999_999.
- `combo` out 4: current combo clamped to 0..9, for single-digit display.
- `max_combo` out 8: highest internal combo reached this game.
- `accuracy` out 8: BCD percent, tens digit in [7:4] and units in [3:0], range 8'h00..8'h99.
- `busy` out 1: accuracy recomputation in progress.

## Operation
- Internal state:
  - `combo_int`: 8 bits, saturates at 255.
  - `n_perfect`, `n_good`, `n_total`: 16 bits each.
  - `pending` flag.
- **Accepted judgement** (`judge_valid` = 1, type 0..2, no `game_start`):
  - PERFECT/GOOD: add `base + 10*min(combo_int, 50)` to score, using the pre-increment `combo_int`. Then increment `combo_int` (saturating) and set `max_combo = max(max_combo, new combo_int)`.
  - MISS: add nothing to score; `combo_int` goes to 0.
  - Counters: if `n_total` < 65535, increment `n_total` and the matching `n_perfect`/`n_good`. If `n_total` = 65535, all three counters freeze; score and combo still update.
- Type 3 is ignored completely: no state change and no recompute.
- Score addition saturates at 999_999 and never wraps.
- **Accuracy**:
  - num = 100*(2*n_perfect + n_good), 24 bits. den = 2*n_total, 17 bits.
  - q = floor(num/den), range 0..100. q = 100 is clamped to 99.
  - Result is converted to BCD (tens = q/10, units = q%10).
  - If n_total = 0, accuracy = 8'h00 and no division runs.
- **FSM**: IDLE, DIV, WRITE.
  - IDLE → DIV on an accepted judgement. Operands are latched from the post-update counter values.
  - DIV: restoring divider, one quotient bit per cycle, exactly 24 cycles.
  - WRITE: updates `accuracy`, then goes to IDLE. If `pending` is set, WRITE instead clears `pending` and goes to DIV with freshly latched operands.
  - An accepted judgement while in DIV or WRITE sets `pending`. Multiple judgements during one computation collapse into a single rerun.
- **`game_start`** (and reset):
  - Clears score, combo_int, max_combo, counters, accuracy and pending; FSM → IDLE.
  - Aborts any division in progress.
  - Takes priority over a simultaneous `judge_valid`, which is dropped.
- Reset values: `score` 0, `combo` 0, `max_combo` 0, `accuracy` 8'h00, `busy` 0.

## Timing
- Judgement sampled at rising edge T:
  - `score`, `combo` and `max_combo` show the new values after edge T (1-cycle latency).
  - FSM enters DIV at edge T; DIV occupies edges T+1..T+24.
  - `accuracy` is written at edge T+25 and is valid from then on.
- `busy` is high from after edge T until edge T+25, when it falls unless a rerun starts. On a rerun, `busy` stays high continuously and the next write happens 25 cycles after the rerun entry.
- Back-to-back `judge_valid` every cycle is legal. Score and combo still track each judgement with 1-cycle latency; `accuracy` may lag.
- `game_start` at edge S: all outputs are 0 after S.

## Test plan
- **Reset**: hold `rst_n` = 0 for 2 cycles → all outputs 0 and `busy` = 0. Also assert `rst_n` = 0 mid-DIV → same, with no later `accuracy` write.
- **Three PERFECTs** spaced 30 cycles apart → score 300, 610, 930; combo 3; max_combo 3; accuracy 8'h99 (100 clamped), appearing exactly 25 cycles after each judgement.
- **PERFECT, GOOD, MISS, PERFECT** → score 300, 410, 410, 710; combo ends at 1; max_combo 2; final accuracy 8'h62 (500/8 = 62).
- **Four judgements on consecutive cycles** (P, P, G, M) → score 300, 610, 730, 730 tracking each cycle; `busy` high continuously; final accuracy from p=2, g=1, n=4 = 8'h62, written once after the rerun completes.
- **`game_start` and PERFECT in the same cycle mid-DIV** → all outputs 0 next cycle; `busy` 0; no later `accuracy` write.
- **12 consecutive PERFECTs** → combo saturates at 9; max_combo 12; score 4260; accuracy 8'h99. A type-3 judgement afterwards → no change and `busy` stays 0.
